// File: rtl/mdio_master.sv
// IEEE 802.3 clause-22 MDIO management master: free-running MDC divider plus a
// frame sequencer that issues one read or write frame per accepted request.
module mdio_master #(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy_addr,
    input  logic [4:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_START,
        ST_OPCODE,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  div_cnt_r;
    logic        mdc_r;
    logic        tc_s;
    logic        fall_evt_s;
    logic        rise_evt_s;

    state_t      state_r;
    logic [5:0]  bit_cnt_r;
    logic        start_pend_r;
    logic        is_read_r;
    logic [63:0] frame_r;
    logic [15:0] rd_sh_r;
    logic        ta_err_r;
    logic        mdio_o_r;
    logic        mdio_oe_r;
    logic        req_ready_r;
    logic        busy_r;
    logic        rsp_valid_r;
    logic [15:0] rsp_rdata_r;
    logic        rsp_err_r;

    // Index of the last bit of each frame field.
    function automatic logic [5:0] field_last(input state_t s);
        logic [5:0] last;
        case (s)
            ST_PREAMBLE: last = 6'd31;
            ST_START:    last = 6'd1;
            ST_OPCODE:   last = 6'd1;
            ST_PHYAD:    last = 6'd4;
            ST_REGAD:    last = 6'd4;
            ST_TA:       last = 6'd1;
            ST_DATA:     last = 6'd15;
            default:     last = 6'd0;
        endcase
        return last;
    endfunction

    // Field sequence; anything unexpected falls back to IDLE.
    function automatic state_t field_next(input state_t s);
        state_t nxt;
        case (s)
            ST_PREAMBLE: nxt = ST_START;
            ST_START:    nxt = ST_OPCODE;
            ST_OPCODE:   nxt = ST_PHYAD;
            ST_PHYAD:    nxt = ST_REGAD;
            ST_REGAD:    nxt = ST_TA;
            ST_TA:       nxt = ST_DATA;
            default:     nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // MDC divider: toggle mdc and wrap on terminal count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_r <= 8'd0;
            mdc_r     <= 1'b0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 8'd0;
            mdc_r     <= ~mdc_r;
        end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
        end
    end

    // MDC edge strobes, aligned with the clk edge that changes mdc.
    always_comb begin
        tc_s       = (div_cnt_r == DIV_LAST);
        fall_evt_s = tc_s && mdc_r;
        rise_evt_s = tc_s && !mdc_r;
    end

    // Frame sequencer, read sampling and handshake registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 6'd0;
            start_pend_r <= 1'b0;
            is_read_r    <= 1'b0;
            frame_r      <= 64'h0;
            rd_sh_r      <= 16'h0000;
            ta_err_r     <= 1'b0;
            mdio_o_r     <= 1'b1;
            mdio_oe_r    <= 1'b0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 16'h0000;
            rsp_err_r    <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;

            if (rise_evt_s && is_read_r) begin
                if (state_r == ST_TA && bit_cnt_r == 6'd1) begin
                    ta_err_r <= mdio_i;
                end else if (state_r == ST_DATA) begin
                    rd_sh_r <= {rd_sh_r[14:0], mdio_i};
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_pend_r) begin
                        // First bit waits for a fall event after the acceptance edge.
                        if (fall_evt_s) begin
                            start_pend_r <= 1'b0;
                            state_r      <= ST_PREAMBLE;
                            bit_cnt_r    <= 6'd0;
                            mdio_oe_r    <= 1'b1;
                            mdio_o_r     <= frame_r[63];
                            frame_r      <= {frame_r[62:0], 1'b0};
                        end
                    end else if (!req_ready_r) begin
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else if (req_valid) begin
                        req_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        start_pend_r <= 1'b1;
                        is_read_r    <= !req_write;
                        frame_r      <= {32'hFFFF_FFFF, 2'b01,
                                         (req_write ? 2'b01 : 2'b10),
                                         req_phy_addr, req_reg_addr, 2'b10,
                                         (req_write ? req_wdata : 16'hFFFF)};
                    end
                end
                default: begin
                    if (fall_evt_s) begin
                        frame_r <= {frame_r[62:0], 1'b0};
                        if (bit_cnt_r == field_last(state_r)) begin
                            bit_cnt_r <= 6'd0;
                            state_r   <= field_next(state_r);
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end

                        if (state_r == ST_DATA && bit_cnt_r == 6'd15) begin
                            mdio_oe_r   <= 1'b0;
                            mdio_o_r    <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            if (is_read_r) begin
                                rsp_rdata_r <= rd_sh_r;
                                rsp_err_r   <= ta_err_r;
                            end
                        end else if (is_read_r && state_r == ST_REGAD && bit_cnt_r == 6'd4) begin
                            // Release the line to the PHY for turnaround and data.
                            mdio_oe_r <= 1'b0;
                            mdio_o_r  <= 1'b1;
                        end else if (mdio_oe_r) begin
                            mdio_o_r <= frame_r[63];
                        end else begin
                            mdio_o_r <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign mdc       = mdc_r;
    assign mdio_o    = mdio_o_r;
    assign mdio_oe   = mdio_oe_r;
    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mdio_master.sv
// Directed testbench for mdio_master with a behavioural PHY and line-bit recorder.
module tb_mdio_master;

    localparam int DIV = 4;
    localparam int FRAME_CYC = 64 * 2 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_phy_addr = 5'd0;
    logic [4:0]  req_reg_addr = 5'd0;
    logic [15:0] req_wdata = 16'h0000;
    logic        mdio_i = 1'b1;
    logic        req_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe;
    logic [15:0] rsp_rdata;

    mdio_master #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
        .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state, updated once per cycle by step().
    int          cyc = 0;
    logic        mdc_prev = 1'b0;
    logic        prev_oe = 1'b0;
    bit          in_frame = 1'b0;
    int          nbits = 0;
    logic [63:0] rec_o = 64'h0;
    logic [63:0] rec_oe = 64'h0;
    int          first_cyc = 0;
    int          accept_cyc = 0;
    int          valid_cyc = 0;
    int          nvalid = 0;
    int          naccept = 0;
    logic        valid_o = 1'b0;
    logic        valid_oe = 1'b0;
    int          oe_low_run = 0;
    int          min_gap = 1000000;
    int          frames_seen = 0;
    bit          phy_present = 1'b0;
    logic [15:0] phy_data = 16'h0000;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic phy_bit(input int n);
        if (n == 47) return phy_present ? 1'b0 : 1'b1;
        if (n >= 48 && n < 64) return phy_present ? phy_data[63 - n] : 1'b1;
        return 1'b1;
    endfunction

    task automatic step();
        if (req_valid && req_ready) naccept++;
        @(negedge clk);
        cyc++;
        if (mdc_prev && !mdc) begin
            if (!in_frame && mdio_oe) begin
                in_frame  = 1'b1;
                nbits     = 0;
                first_cyc = cyc;
            end
            if (in_frame) mdio_i = phy_bit(nbits);
        end
        if (!mdc_prev && mdc && in_frame && nbits < 64) begin
            rec_o[63 - nbits]  = mdio_o;
            rec_oe[63 - nbits] = mdio_oe;
            nbits++;
        end
        if (rsp_valid) begin
            nvalid++;
            valid_cyc = cyc;
            valid_o   = mdio_o;
            valid_oe  = mdio_oe;
            in_frame  = 1'b0;
            mdio_i    = 1'b1;
        end
        if (!prev_oe && mdio_oe) begin
            if (frames_seen > 0 && oe_low_run < min_gap) min_gap = oe_low_run;
            frames_seen++;
        end
        if (!mdio_oe) oe_low_run++;
        else oe_low_run = 0;
        prev_oe  = mdio_oe;
        mdc_prev = mdc;
    endtask

    task automatic reset_mon();
        in_frame    = 1'b0;
        nbits       = 0;
        rec_o       = 64'h0;
        rec_oe      = 64'h0;
        mdio_i      = 1'b1;
        mdc_prev    = mdc;
        prev_oe     = mdio_oe;
        frames_seen = 0;
        min_gap     = 1000000;
        oe_low_run  = 0;
    endtask

    task automatic send_req(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd);
        int i;
        req_write    = wr;
        req_phy_addr = phy;
        req_reg_addr = rg;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (i = 0; i < 4 * DIV && !req_ready; i++) step();
        step();
        accept_cyc = cyc;
        req_valid  = 1'b0;
        check_val("accept_busy", {busy, req_ready}, 64'h2);
    endtask

    task automatic wait_valid(input int target, input string tag);
        int i;
        for (i = 0; i < FRAME_CYC + 8 * DIV && nvalid < target; i++) step();
        if (nvalid < target) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Runs one frame and checks timing/handshake common to every frame.
    task automatic run_frame(input string tag, input logic wr, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wd);
        int nv;
        nv = nvalid;
        send_req(wr, phy, rg, wd);
        wait_valid(nv + 1, tag);
        check_val({tag, "_first_bit_delay"},
                  64'((first_cyc - accept_cyc >= 1) && (first_cyc - accept_cyc <= 2 * DIV)), 64'd1);
        check_val({tag, "_frame_len"}, 64'(valid_cyc - first_cyc), 64'(FRAME_CYC));
        check_val({tag, "_end_line"}, {valid_oe, valid_o}, 64'h1);
        repeat (3 * DIV) step();
        check_val({tag, "_one_pulse"}, 64'(nvalid), 64'(nv + 1));
        check_val({tag, "_ready_after"}, {busy, req_ready}, 64'h1);
    endtask

    task automatic wait_mdc(input logic lvl, output int at);
        int i;
        for (i = 0; i < 2 * DIV + 4 && mdc !== lvl; i++) step();
        at = cyc;
        if (mdc !== lvl) check_val("mdc_timeout", 64'd0, 64'd1);
    endtask

    logic [45:0] exp_hdr;
    logic [63:0] exp_frame;
    int t0, t1, t2, t3, nv_save;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (10) step();
        check_val("rst_mdc_oe_o", {mdc, mdio_oe, mdio_o}, 64'h1);
        check_val("rst_ready_busy_valid", {req_ready, busy, rsp_valid}, 64'h4);
        check_val("rst_rdata_err", {rsp_rdata, rsp_err}, 64'h0);
        rst = 1'b1;
        reset_mon();

        // MDC period and duty
        wait_mdc(1'b0, t0);
        wait_mdc(1'b1, t1);
        wait_mdc(1'b0, t2);
        wait_mdc(1'b1, t3);
        check_val("mdc_high", 64'(t2 - t1), 64'(DIV));
        check_val("mdc_period", 64'(t3 - t1), 64'(2 * DIV));

        // Read phy=1 reg=1 with PHY returning 7849
        reset_mon();
        phy_present = 1'b1;
        phy_data    = 16'h7849;
        run_frame("rd1", 1'b0, 5'd1, 5'd1, 16'h0000);
        exp_hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd1};
        check_val("rd1_hdr_bits", 64'(rec_o[63:18]), 64'(exp_hdr));
        check_val("rd1_released_ones", 64'(rec_o[17:0]), 64'h3FFFF);
        check_val("rd1_oe_pattern", rec_oe, {46'h3FFF_FFFF_FFFF, 18'h0});
        check_val("rd1_rdata", 64'(rsp_rdata), 64'h7849);
        check_val("rd1_err", 64'(rsp_err), 64'd0);

        // Write phy=3 reg=0 data=1140
        reset_mon();
        phy_present = 1'b0;
        run_frame("wr1", 1'b1, 5'd3, 5'd0, 16'h1140);
        exp_frame = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd0, 2'b10, 16'h1140};
        check_val("wr1_bits", rec_o, exp_frame);
        check_val("wr1_oe_all", rec_oe, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("wr1_rdata_kept", {rsp_rdata, rsp_err}, {16'h7849, 1'b0});

        // Read with no PHY
        reset_mon();
        phy_present = 1'b0;
        run_frame("rd_nophy", 1'b0, 5'd31, 5'd2, 16'h0000);
        check_val("rd_nophy_err", 64'(rsp_err), 64'd1);
        check_val("rd_nophy_rdata", 64'(rsp_rdata), 64'hFFFF);

        // Back-to-back requests with req_valid held high
        reset_mon();
        naccept      = 0;
        nv_save      = nvalid;
        req_write    = 1'b1;
        req_phy_addr = 5'd7;
        req_reg_addr = 5'd9;
        req_wdata    = 16'hBEEF;
        req_valid    = 1'b1;
        for (int i = 0; i < 4 * DIV && naccept < 1; i++) step();
        req_phy_addr = 5'd12;
        req_reg_addr = 5'd21;
        req_wdata    = 16'h0123;
        for (int i = 0; i < FRAME_CYC + 8 * DIV && naccept < 2; i++) step();
        req_valid = 1'b0;
        check_val("b2b_second_accept", 64'(naccept), 64'd2);
        check_val("b2b_after_valid", 64'(nvalid - nv_save), 64'd1);
        check_val("b2b_frame_a", rec_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, 5'd9, 2'b10, 16'hBEEF});
        for (int k = 0; k < 5; k++) begin
            repeat (10) step();
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
        end
        wait_valid(nv_save + 2, "b2b");
        check_val("b2b_frame_b", rec_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd12, 5'd21, 2'b10, 16'h0123});
        check_val("b2b_gap", 64'(min_gap >= 2 * DIV), 64'd1);
        repeat (FRAME_CYC + 4 * DIV) step();
        check_val("b2b_no_extra_frames", {32'(nvalid - nv_save), 32'(naccept)}, {32'd2, 32'd2});

        // Reset during DATA of a write
        reset_mon();
        nv_save = nvalid;
        send_req(1'b1, 5'd2, 5'd4, 16'hA5A5);
        for (int i = 0; i < FRAME_CYC && nbits < 55; i++) step();
        check_val("mid_reached_data", 64'(nbits >= 55), 64'd1);
        rst = 1'b0;
        step();
        check_val("mid_rst_line", {mdio_oe, mdc, mdio_o}, 64'h1);
        check_val("mid_rst_hs", {req_ready, busy, rsp_valid}, 64'h4);
        rst = 1'b1;
        repeat (FRAME_CYC / 4) step();
        check_val("mid_rst_no_valid", 64'(nvalid), 64'(nv_save));
        reset_mon();
        run_frame("post_rst", 1'b1, 5'd5, 5'd17, 16'h0F0F);
        check_val("post_rst_bits", rec_o, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd5, 5'd17, 2'b10, 16'h0F0F});
        check_val("post_rst_oe_all", rec_oe, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter CLK_DIV, default 20, MDC half-period in clk cycles (legal range 2..255); MDC period = 2*CLK_DIV clk cycles.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  management request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_write  input  1  1 = write frame (OP=01), 0 = read frame (OP=10).
REQ-007 req_phy_addr  input  5  PHY address.
REQ-008 req_reg_addr  input  5  register address.
REQ-009 req_wdata  input  16  write data, ignored for reads.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  16  read data; held until next completion.
REQ-012 rsp_err  output  1  read turnaround error; held until next completion.
REQ-013 busy  output  1  frame in progress (inverse of req_ready).
REQ-014 mdc  output  1  management clock to PHY.
REQ-015 mdio_o  output  1  MDIO drive value.
REQ-016 mdio_oe  output  1  1 = block drives MDIO; tristate buffer is external.
REQ-017 mdio_i  input  1  MDIO sampled line (externally pulled up).

Function
REQ-018 mdc SHALL be free-running: divider counts 0..CLK_DIV-1, mdc toggles and counter wraps on terminal count.
REQ-019 A "fall event" is the clk edge at which mdc goes 1->0; a "rise event" is the clk edge at which mdc goes 0->1.
REQ-020 mdio_o/mdio_oe SHALL change only on fall events; mdio_i SHALL be sampled only on rise events (value present before that edge).
REQ-021 Request accepted when req_valid && req_ready on a clk edge; all req_* fields captured; req_ready low and busy high from the next cycle.
REQ-022 req_valid while busy SHALL be ignored; no queueing.
REQ-023 First frame bit driven on the first fall event strictly after the acceptance edge.
REQ-024 Frame order, MSB first, one bit per MDC period: 32 preamble 1s, ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]; 64 bits total.
REQ-025 States: IDLE, PREAMBLE, START, OPCODE, PHYAD, REGAD, TA, DATA; 6-bit bit counter, cleared on each state transition.
REQ-026 Write: mdio_oe=1 for all 64 bits; TA driven as 1,0; DATA driven from captured req_wdata.
REQ-027 Read: mdio_oe=1 for first 46 bits; mdio_oe=0 from the first TA bit to end of frame.
REQ-028 Read: second TA bit sampled on its rise event; 1 -> rsp_err=1, else rsp_err=0. Frame completes regardless.
REQ-029 Read: DATA bits shifted into rsp_rdata MSB first on the 16 DATA rise events.
REQ-030 Completion on the fall event ending bit 64: mdio_oe=0, mdio_o=1, rsp_valid=1 for exactly that one cycle, state to IDLE, req_ready=1 on the following cycle.
REQ-031 rsp_rdata/rsp_err SHALL update only at read completion; a write completion leaves them unchanged and keeps rsp_err=0 semantics unaffected.
REQ-032 Consecutive frames SHALL be separated by at least one full MDC period with mdio_oe=0 (guaranteed by REQ-023/REQ-030).
REQ-033 mdio_o SHALL be 1 whenever mdio_oe=0.

Reset
REQ-034 While rst=0 at a clk edge: mdc=0, divider=0, state IDLE, mdio_oe=0, mdio_o=1, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=16'h0000, rsp_err=0.
REQ-035 Reset mid-frame SHALL abort the frame with no rsp_valid; outputs take REQ-034 values the cycle after the reset edge.

Verification
REQ-036 Hold rst=0 10 cycles -> all outputs at REQ-034 values; release -> mdc period 2*CLK_DIV cycles, 50% duty.
REQ-037 Read phy=1 reg=1, PHY model drives TA2=0 and 16'h7849 -> line bits 32x1,01,10,00001,00001; mdio_oe falls at bit 47; rsp_rdata=16'h7849, rsp_err=0, single rsp_valid pulse 64 MDC periods after first bit.
REQ-038 Write phy=3 reg=0 data=16'h1140 -> bits 32x1,01,01,00011,00000,10,0001000101000000 with mdio_oe=1 for all 64; rsp_valid pulse; rsp_rdata unchanged.
REQ-039 Read with no PHY (mdio_i=1) -> rsp_err=1, rsp_rdata=16'hFFFF.
REQ-040 req_valid held high for two requests -> second accepted only after rsp_valid; ≥1 MDC period with mdio_oe=0 between frames; extra req_valid pulses during busy produce no frame.
REQ-041 Assert rst=0 during DATA of a write -> next cycle mdio_oe=0, mdc=0, req_ready=1, no rsp_valid; subsequent request runs a full correct frame.
